instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_instr_mem.sv | 28 ++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the word width, FSM state encodings, default halt encoding and an alignment helper.
package instr_fetch_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_instr_mem.sv
// Instruction memory: synchronous write, combinational read.
// Latency: writes land at the clock edge and reads are zero-cycle; there is no backpressure.
module instr_mem
  import instr_fetch_unit_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  // No reset on the array, so a loaded program survives a reset.
  logic [WORD_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: program load, PC sequencing with stall/jump/branch, and halt detection.
// Latency: the instruction is read combinationally from the PC; i_stall holds the PC and blocks the IF/ID write.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                MEM_WORDS = 256,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_wr_en,
  input  logic [WORD_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_stall,
  input  logic              i_branch_taken,
  input  logic [WORD_W-1:0] i_branch_addr,
  input  logic              i_jump,
  input  logic [WORD_W-1:0] i_jump_addr,
  output logic [WORD_W-1:0] o_pc,
  output logic [WORD_W-1:0] o_instruction,
  output logic              o_write_IF_ID,
  output logic              o_halt,
  output logic [1:0]        o_state
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [1:0]        state;
  logic [WORD_W-1:0] pc;
  logic              mem_wr;
  logic              is_halt;
  logic              unused_bits;

  assign mem_wr = (state == ST_LOAD) && i_wr_en;

  instr_mem #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_instr_mem (
    .clk     (clk),
    .wr_en   (mem_wr),
    .wr_addr (i_wr_addr[AW+1:2]),
    .wr_data (i_wr_data),
    .rd_addr (pc[AW+1:2]),
    .rd_data (o_instruction)
  );

  // Address bits outside the word index are deliberately dropped (byte offset and wrap).
  assign unused_bits = ^{i_wr_addr[WORD_W-1:AW+2], i_wr_addr[1:0], pc[WORD_W-1:AW+2], pc[1:0]};

  assign is_halt       = (o_instruction == HALT_WORD);
  assign o_pc          = pc + 32'd4;
  assign o_write_IF_ID = (state == ST_RUN) && !i_stall && !is_halt;
  assign o_halt        = (state == ST_HALTED);
  assign o_state       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
      pc    <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          pc <= '0;
          if (i_start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A redirect beats the halt word: that halt was fetched speculatively.
          if (i_stall) begin
            pc <= pc;
          end else if (i_jump) begin
            pc <= align_word(i_jump_addr);
          end else if (i_branch_taken) begin
            pc <= align_word(i_branch_addr);
          end else if (is_halt) begin
            state <= ST_HALTED;
          end else begin
            pc <= pc + 32'd4;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_LOAD;
          pc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven check of instr_fetch_unit: load, run, stall, redirect, halt and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_wr_en, i_stall, i_branch_taken, i_jump;
  logic [31:0] i_wr_addr, i_wr_data, i_branch_addr, i_jump_addr;
  logic [31:0] o_pc, o_instruction;
  logic        o_write_IF_ID, o_halt;
  logic [1:0]  o_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_wr_en        (i_wr_en),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_branch_addr  (i_branch_addr),
    .i_jump         (i_jump),
    .i_jump_addr    (i_jump_addr),
    .o_pc           (o_pc),
    .o_instruction  (o_instruction),
    .o_write_IF_ID  (o_write_IF_ID),
    .o_halt         (o_halt),
    .o_state        (o_state)
  );

  // Inputs are held for one cycle; expected outputs are observed before the edge that commits them.
  typedef struct {
    logic        rst, start, wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        stall, br;
    logic [31:0] br_addr;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic        chk_ins;
    logic [31:0] e_pc, e_ins;
    logic        e_wif, e_halt;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] H = 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic st, input logic we, input logic [31:0] wa,
                     input logic [31:0] wd, input logic sl, input logic b, input logic [31:0] ba,
                     input logic j, input logic [31:0] ja, input logic ci, input logic [31:0] ep,
                     input logic [31:0] ei, input logic ew, input logic eh, input logic [1:0] es);
    vec_t v;
    v = '{r, st, we, wa, wd, sl, b, ba, j, ja, ci, ep, ei, ew, eh, es};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst            = v.rst;
    i_start        = v.start;
    i_wr_en        = v.wr_en;
    i_wr_addr      = v.wr_addr;
    i_wr_data      = v.wr_data;
    i_stall        = v.stall;
    i_branch_taken = v.br;
    i_branch_addr  = v.br_addr;
    i_jump         = v.jmp;
    i_jump_addr    = v.jmp_addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst st we wr_addr wr_data stall br br_addr jmp jmp_addr | chk  o_pc  instr  wif halt state
    // Program load: write at 0x402 wraps to word 0 and is then overwritten.
    add(0,0,1,32'h402,32'hAAAA_0000, 0,0,0, 0,0,   0, 32'h4, 0,          0,0,0);
    add(0,0,1,32'h004,32'h22,        0,0,0, 0,0,   1, 32'h4, 32'hAAAA_0000,0,0,0);
    add(0,0,1,32'h000,32'h11,        0,0,0, 0,0,   1, 32'h4, 32'hAAAA_0000,0,0,0);
    add(0,1,1,32'h008,H,             0,0,0, 0,0,   1, 32'h4, 32'h11,     0,0,0);
    // Run 0x11, 0x22, then the halt word stops fetch at pc 8.
    add(0,0,0,0,0,                   0,0,0, 0,0,   1, 32'h4, 32'h11,     1,0,1);
    add(0,0,0,0,0,                   0,0,0, 0,0,   1, 32'h8, 32'h22,     1,0,1);
    add(0,0,0,0,0,                   0,0,0, 0,0,   1, 32'hC, H,          0,0,1);
    add(0,1,1,32'h000,32'h99,        0,0,0, 0,0,   1, 32'hC, H,          0,1,2);
    add(0,1,0,0,0,                   0,1,32'h80, 1,32'h40, 1, 32'hC, H,  0,1,2);
    add(1,0,0,0,0,                   0,0,0, 0,0,   1, 32'hC, H,          0,1,2);
    // After reset the program survives and the halted-state write was dropped.
    add(0,0,1,32'h010,H,             0,0,0, 0,0,   1, 32'h4, 32'h11,     0,0,0);
    add(0,0,1,32'h080,32'h88,        0,0,0, 0,0,   1, 32'h4, 32'h11,     0,0,0);
    add(0,0,1,32'h020,32'h2020,      0,0,0, 0,0,   1, 32'h4, 32'h11,     0,0,0);
    add(0,1,1,32'h040,32'h44,        0,0,0, 0,0,   1, 32'h4, 32'h11,     0,0,0);
    // Stall at pc 0, then three stalls at pc 4.
    add(0,0,0,0,0,                   1,0,0, 0,0,   1, 32'h4, 32'h11,     0,0,1);
    add(0,0,0,0,0,                   0,0,0, 0,0,   1, 32'h4, 32'h11,     1,0,1);
    add(0,0,0,0,0,                   1,0,0, 0,0,   1, 32'h8, 32'h22,     0,0,1);
    add(0,0,0,0,0,                   1,0,0, 0,0,   1, 32'h8, 32'h22,     0,0,1);
    add(0,0,0,0,0,                   1,0,0, 0,0,   1, 32'h8, 32'h22,     0,0,1);
    add(0,0,0,0,0,                   0,0,0, 0,0,   1, 32'h8, 32'h22,     1,0,1);
    // pc 8 holds the halt word: stall wins over both redirects, then jump wins over branch and halt.
    add(0,0,0,0,0,                   1,1,32'h80, 1,32'h40, 1, 32'hC, H,  0,0,1);
    add(0,0,0,0,0,                   0,1,32'h80, 1,32'h43, 1, 32'hC, H,  0,0,1);
    // RUN-time write is ignored; branch target low bits are cleared.
    add(0,0,1,32'h040,32'h55,        0,1,32'h82, 0,0, 1, 32'h44, 32'h44, 1,0,1);
    add(0,0,0,0,0,                   0,1,32'h40, 0,0, 1, 32'h84, 32'h88, 1,0,1);
    add(0,0,0,0,0,                   0,0,0, 1,32'h10, 1, 32'h44, 32'h44, 1,0,1);
    // Halt word at 0x10 with a branch to 0: redirect discards the halt.
    add(0,0,0,0,0,                   0,1,32'h0, 0,0, 1, 32'h14, H,       0,0,1);
    add(0,0,0,0,0,                   0,0,0, 1,32'h20, 1, 32'h4, 32'h11,  1,0,1);
    // Reset at pc 0x20 overrides an in-flight branch.
    add(1,0,0,0,0,                   0,1,32'h80, 0,0, 1, 32'h24, 32'h2020,1,0,1);
    add(0,0,0,0,0,                   0,0,0, 0,0,   1, 32'h4, 32'h11,     0,0,0);

    // Initial reset, held across one edge.
    @(negedge clk);
    drive('{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    @(negedge clk);
    #1;
    chk("reset_state", {30'd0, o_state}, 32'd0);
    chk("reset_pc", o_pc, 32'd4);
    chk("reset_halt", {31'd0, o_halt}, 32'd0);
    chk("reset_wif", {31'd0, o_write_IF_ID}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_pc", i), o_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_wif", i), {31'd0, o_write_IF_ID}, {31'd0, vecs[i].e_wif});
      chk($sformatf("v%0d_halt", i), {31'd0, o_halt}, {31'd0, vecs[i].e_halt});
      chk($sformatf("v%0d_state", i), {30'd0, o_state}, {30'd0, vecs[i].e_state});
      if (vecs[i].chk_ins) begin
        chk($sformatf("v%0d_instr", i), o_instruction, vecs[i].e_ins);
      end
    end

    // Halt reached from a fresh start stays frozen across several idle cycles.
    @(negedge clk);
    drive('{0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    @(negedge clk);
    drive('{0,0,0,0,0,0,0,0,1,32'h10,0,0,0,0,0,0});
    @(negedge clk);
    drive('{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("frozen%0d_halt", k), {31'd0, o_halt}, 32'd1);
      chk($sformatf("frozen%0d_pc", k), o_pc, 32'h14);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
